// File: rtl/servo_pkg.sv
// Shared types and helpers for the servo PWM output stage: Q16.16 sign-magnitude
// angle field positions, the 180-degree limit, the us-width type and angle clamp.
package servo_pkg;

   localparam int unsigned SIGN_BIT = 31;
   localparam int unsigned MAG_MSB  = 30;
   localparam int unsigned INT_LSB  = 16;
   localparam int unsigned FRAC_MSB = 15;

   localparam logic [31:0] ANG_MAX_Q = 32'h00B4_0000;

   typedef logic [15:0] us_t;

   // Negative or zero angles map to 0, anything beyond 180 deg saturates at 180.
   function automatic logic [31:0] clamp_angle(input logic [31:0] ang);
      logic [31:0] mag;
      mag = {1'b0, ang[MAG_MSB:0]};
      if (ang[SIGN_BIT] || (mag == 32'd0)) begin
         clamp_angle = 32'd0;
      end else if (mag > ANG_MAX_Q) begin
         clamp_angle = ANG_MAX_Q;
      end else begin
         clamp_angle = mag;
      end
   endfunction

   // Move cur toward tgt by at most step.
   function automatic us_t slew_step(input us_t cur, input us_t tgt, input us_t step);
      us_t diff;
      if (tgt > cur) begin
         diff      = tgt - cur;
         slew_step = (diff > step) ? (cur + step) : tgt;
      end else begin
         diff      = cur - tgt;
         slew_step = (diff > step) ? (cur - step) : tgt;
      end
   endfunction

endpackage

// File: rtl/servo_angle2us.sv
// One servo channel's angle-to-pulse-width conversion: clamp the Q16.16 angle,
// take it as Q8.8 and scale to microseconds, with a single output register.
module servo_angle2us
   import servo_pkg::*;
#(
   parameter int unsigned MIN_US = 500,
   parameter int unsigned SCALE  = 2844
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] ang_i,
   output us_t         width_o
);

   logic [31:0] mag_s;
   logic [15:0] a88_s;
   logic [31:0] prod_s;
   us_t         width_d;
   us_t         width_q;

   // Clamped magnitude never exceeds 180.0, so bits [23:8] hold the whole Q8.8 value.
   always_comb begin
      mag_s   = clamp_angle(ang_i);
      a88_s   = 16'(mag_s >> 8);
      prod_s  = 32'(a88_s) * SCALE;
      width_d = us_t'(MIN_US) + us_t'(prod_s >> 16);
   end

   // Conversion result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         width_q <= us_t'(MIN_US);
      end else begin
         width_q <= width_d;
      end
   end

   assign width_o = width_q;

endmodule

// File: rtl/servo_pwm_out.sv
// Two-channel hobby-servo PWM generator fed by the IK stage; new widths are applied
// only at period boundaries. Define SERVO_SLEW_EN to rate-limit width changes.
module servo_pwm_out
   import servo_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 50_000_000,
   parameter int unsigned PERIOD_US = 20000,
   parameter int unsigned MIN_US    = 500,
   parameter int unsigned SCALE     = 2844,
   parameter int unsigned RESET_US  = 1500,
   parameter int unsigned SLEW_US   = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        angle_valid,
   input  logic [31:0] xita1,
   input  logic [31:0] xita2,
   output logic        pwm1,
   output logic        pwm2,
   output logic        period_start,
   output logic        applied
);

   localparam int unsigned DIV     = CLK_HZ / 1_000_000;
   localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
   localparam logic [15:0] PER_M1  = 16'(PERIOD_US - 1);
   localparam us_t         RESET_W = us_t'(RESET_US);

   logic [1:0]  rst_sync_d, rst_sync_q;
   logic        rst_int_n;

   logic [15:0] pre_d, pre_q;
   logic [15:0] us_cnt_d, us_cnt_q;
   logic        tick_s, boundary_s, edge_s;
   logic        av_dly_d, av_dly_q;
   logic [31:0] cap1_d, cap1_q, cap2_d, cap2_q;
   logic        cap_vld_d, cap_vld_q, conv_vld_d, conv_vld_q;
   us_t         w1_s, w2_s;
   us_t         pend1_d, pend1_q, pend2_d, pend2_q;
   logic        pend_vld_d, pend_vld_q;
   us_t         act1_d, act1_q, act2_d, act2_q;
   logic        pwm1_d, pwm1_q, pwm2_d, pwm2_q;
   logic        period_start_d, period_start_q;
   logic        applied_d, applied_q;

   // Reset asserts asynchronously and releases on a clock edge.
   always_comb begin
      rst_sync_d = {rst_sync_q[0], 1'b1};
   end

   // Reset synchroniser.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= rst_sync_d;
      end
   end

   assign rst_int_n = rst_sync_q[1];

   servo_angle2us #(.MIN_US(MIN_US), .SCALE(SCALE)) u_conv1 (
      .clk     (clk),
      .rst_n   (rst_int_n),
      .ang_i   (cap1_q),
      .width_o (w1_s)
   );

   servo_angle2us #(.MIN_US(MIN_US), .SCALE(SCALE)) u_conv2 (
      .clk     (clk),
      .rst_n   (rst_int_n),
      .ang_i   (cap2_q),
      .width_o (w2_s)
   );

   // Timebase, capture pipeline, apply and output next-state logic.
   always_comb begin
      tick_s = 1'b0;
      pre_d  = 16'd0;
      us_cnt_d = 16'd0;
      if (enable) begin
         tick_s = (pre_q == DIV_M1);
         if (tick_s) begin
            pre_d = 16'd0;
            us_cnt_d = (us_cnt_q == PER_M1) ? 16'd0 : (us_cnt_q + 16'd1);
         end else begin
            pre_d = pre_q + 16'd1;
            us_cnt_d = us_cnt_q;
         end
      end else begin
         pre_d    = 16'd0;
         us_cnt_d = 16'd0;
      end
      boundary_s = tick_s && (us_cnt_q == PER_M1);

      av_dly_d = angle_valid;
      edge_s   = angle_valid && !av_dly_q;
      if (edge_s) begin
         cap1_d = xita1;
         cap2_d = xita2;
      end else begin
         cap1_d = cap1_q;
         cap2_d = cap2_q;
      end
      cap_vld_d  = edge_s;
      conv_vld_d = cap_vld_q;

      pend1_d    = pend1_q;
      pend2_d    = pend2_q;
      pend_vld_d = pend_vld_q;
      act1_d     = act1_q;
      act2_d     = act2_q;
      applied_d  = 1'b0;
      // Apply uses the registered pending flag, so a pair landing on a boundary waits one period.
      if (boundary_s && pend_vld_q) begin
`ifdef SERVO_SLEW_EN
         act1_d = slew_step(act1_q, pend1_q, us_t'(SLEW_US));
         act2_d = slew_step(act2_q, pend2_q, us_t'(SLEW_US));
         if ((act1_d == pend1_q) && (act2_d == pend2_q)) begin
            pend_vld_d = 1'b0;
            applied_d  = 1'b1;
         end else begin
            pend_vld_d = 1'b1;
            applied_d  = 1'b0;
         end
`else
         act1_d     = pend1_q;
         act2_d     = pend2_q;
         pend_vld_d = 1'b0;
         applied_d  = 1'b1;
`endif
      end else begin
         act1_d = act1_q;
         act2_d = act2_q;
      end
      // A freshly converted pair overrides anything still pending: latest pair wins.
      if (conv_vld_q) begin
         pend1_d    = w1_s;
         pend2_d    = w2_s;
         pend_vld_d = 1'b1;
      end else begin
         pend1_d = pend1_q;
         pend2_d = pend2_q;
      end

      pwm1_d         = (us_cnt_q < act1_q) && enable;
      pwm2_d         = (us_cnt_q < act2_q) && enable;
      period_start_d = boundary_s;
   end

`ifndef SERVO_SLEW_EN
   logic [15:0] unused_slew_s;
   assign unused_slew_s = 16'(SLEW_US);
`endif

   // State and output registers.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         pre_q          <= 16'd0;
         us_cnt_q       <= 16'd0;
         av_dly_q       <= 1'b0;
         cap1_q         <= 32'd0;
         cap2_q         <= 32'd0;
         cap_vld_q      <= 1'b0;
         conv_vld_q     <= 1'b0;
         pend1_q        <= RESET_W;
         pend2_q        <= RESET_W;
         pend_vld_q     <= 1'b0;
         act1_q         <= RESET_W;
         act2_q         <= RESET_W;
         pwm1_q         <= 1'b0;
         pwm2_q         <= 1'b0;
         period_start_q <= 1'b0;
         applied_q      <= 1'b0;
      end else begin
         pre_q          <= pre_d;
         us_cnt_q       <= us_cnt_d;
         av_dly_q       <= av_dly_d;
         cap1_q         <= cap1_d;
         cap2_q         <= cap2_d;
         cap_vld_q      <= cap_vld_d;
         conv_vld_q     <= conv_vld_d;
         pend1_q        <= pend1_d;
         pend2_q        <= pend2_d;
         pend_vld_q     <= pend_vld_d;
         act1_q         <= act1_d;
         act2_q         <= act2_d;
         pwm1_q         <= pwm1_d;
         pwm2_q         <= pwm2_d;
         period_start_q <= period_start_d;
         applied_q      <= applied_d;
      end
   end

   assign pwm1         = pwm1_q;
   assign pwm2         = pwm2_q;
   assign period_start = period_start_q;
   assign applied      = applied_q;

endmodule

// File: tb/tb_servo_pwm_out.sv
// Directed bench for servo_pwm_out, run with a 2 MHz clock and a 2600 us period so
// each PWM period is 5200 clocks and a width of W us is high for 2*W clocks.
module tb_servo_pwm_out;

   localparam int unsigned CLK_HZ    = 2_000_000;
   localparam int unsigned PERIOD_US = 2600;
   localparam int          PER_CLK   = 5200;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        angle_valid = 1'b0;
   logic [31:0] xita1 = 32'd0;
   logic [31:0] xita2 = 32'd0;
   logic        pwm1, pwm2, period_start, applied;

   int checks = 0;
   int failures = 0;

   servo_pwm_out #(
      .CLK_HZ(CLK_HZ), .PERIOD_US(PERIOD_US), .MIN_US(500), .SCALE(2844),
      .RESET_US(1500), .SLEW_US(20)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .angle_valid(angle_valid),
      .xita1(xita1), .xita2(xita2), .pwm1(pwm1), .pwm2(pwm2),
      .period_start(period_start), .applied(applied)
   );

   always #5 clk = ~clk;

   task automatic wait_start(input string name);
      int n;
      n = 0;
      while (period_start !== 1'b1 && n < 2 * PER_CLK + 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (period_start !== 1'b1) begin
         failures++;
         $display("FAIL %s_start: period_start not seen after %0d clocks, expected within %0d", name, n, 2 * PER_CLK + 100);
      end
   endtask

   // Measures one full period from a period_start sample, optionally pulsing angle_valid at two sample indices.
   task automatic measure(input string name, input int inj_a, input logic [31:0] a1, input logic [31:0] a2,
                          input int inj_b, input logic [31:0] b1, input logic [31:0] b2,
                          output int h1, output int h2, output int ap);
      h1 = 0; h2 = 0; ap = 0;
      wait_start(name);
      for (int i = 0; i < PER_CLK; i++) begin
         if (pwm1 === 1'b1) h1++;
         if (pwm2 === 1'b1) h2++;
         if (applied === 1'b1) ap++;
         if (i == inj_a) begin xita1 = a1; xita2 = a2; angle_valid = 1'b1; end
         if (i == inj_b) begin xita1 = b1; xita2 = b2; angle_valid = 1'b1; end
         if (i == inj_a + 4 || i == inj_b + 4) angle_valid = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      int h1, h2, ap;
      rst_n = 1'b0; enable = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (pwm1 !== 1'b0) begin failures++; $display("FAIL reset_pwm1: got %b expected 0", pwm1); end
      checks++; if (pwm2 !== 1'b0) begin failures++; $display("FAIL reset_pwm2: got %b expected 0", pwm2); end
      checks++; if (period_start !== 1'b0) begin failures++; $display("FAIL reset_period_start: got %b expected 0", period_start); end
      checks++; if (applied !== 1'b0) begin failures++; $display("FAIL reset_applied: got %b expected 0", applied); end
      rst_n = 1'b1;
      measure("reset", -1, 32'd0, 32'd0, -1, 32'd0, 32'd0, h1, h2, ap);
      checks++; if (h1 !== 3000) begin failures++; $display("FAIL reset_width1: got %0d clocks expected 3000", h1); end
      checks++; if (h2 !== 3000) begin failures++; $display("FAIL reset_width2: got %0d clocks expected 3000", h2); end
      checks++; if (ap !== 0) begin failures++; $display("FAIL reset_applied_count: got %0d expected 0", ap); end
   endtask

   task automatic test_update();
      int h1, h2, ap;
      measure("update_cur", 1000, 32'h005A_0000, 32'h0000_0000, -1, 32'd0, 32'd0, h1, h2, ap);
      checks++; if (h1 !== 3000 || h2 !== 3000) begin failures++; $display("FAIL update_cur_width: got %0d/%0d expected 3000/3000", h1, h2); end
      checks++; if (ap !== 0) begin failures++; $display("FAIL update_cur_applied: got %0d expected 0", ap); end
      measure("update_next", -1, 32'd0, 32'd0, -1, 32'd0, 32'd0, h1, h2, ap);
      checks++; if (ap !== 1) begin failures++; $display("FAIL update_applied: got %0d expected 1", ap); end
      checks++; if (h1 !== 2998) begin failures++; $display("FAIL update_width1: got %0d expected 2998", h1); end
      checks++; if (h2 !== 1000) begin failures++; $display("FAIL update_width2: got %0d expected 1000", h2); end
   endtask

   task automatic test_clamp();
      int h1, h2, ap;
      measure("clamp_cur", 100, 32'h801E_0000, 32'h00C8_0000, -1, 32'd0, 32'd0, h1, h2, ap);
      checks++; if (h1 !== 2998 || h2 !== 1000 || ap !== 0) begin failures++; $display("FAIL clamp_cur: got %0d/%0d ap=%0d expected 2998/1000 ap=0", h1, h2, ap); end
      measure("clamp_next", -1, 32'd0, 32'd0, -1, 32'd0, 32'd0, h1, h2, ap);
      checks++; if (h1 !== 1000) begin failures++; $display("FAIL clamp_negative: got %0d expected 1000", h1); end
      checks++; if (h2 !== 4998) begin failures++; $display("FAIL clamp_over180: got %0d expected 4998", h2); end
      checks++; if (ap !== 1) begin failures++; $display("FAIL clamp_applied: got %0d expected 1", ap); end
   endtask

   task automatic test_latest_wins();
      int h1, h2, ap;
      measure("latest_cur", 100, 32'h002D_0000, 32'h002D_0000, 2000, 32'h0087_0000, 32'h005A_0000, h1, h2, ap);
      checks++; if (h1 !== 1000 || h2 !== 4998 || ap !== 0) begin failures++; $display("FAIL latest_cur: got %0d/%0d ap=%0d expected 1000/4998 ap=0", h1, h2, ap); end
      measure("latest_next", -1, 32'd0, 32'd0, -1, 32'd0, 32'd0, h1, h2, ap);
      checks++; if (h1 !== 3998) begin failures++; $display("FAIL latest_width1: got %0d expected 3998", h1); end
      checks++; if (h2 !== 2998) begin failures++; $display("FAIL latest_width2: got %0d expected 2998", h2); end
      checks++; if (ap !== 1) begin failures++; $display("FAIL latest_applied: got %0d expected 1", ap); end
      measure("latest_after", -1, 32'd0, 32'd0, -1, 32'd0, 32'd0, h1, h2, ap);
      checks++; if (ap !== 0 || h1 !== 3998) begin failures++; $display("FAIL latest_single_apply: got ap=%0d w1=%0d expected ap=0 w1=3998", ap, h1); end
   endtask

   task automatic test_enable();
      int n, h1, h2, ps;
      wait_start("enable");
      repeat (500) @(negedge clk);
      checks++; if (pwm1 !== 1'b1) begin failures++; $display("FAIL enable_pre_drop: got %b expected 1", pwm1); end
      enable = 1'b0;
      xita1 = 32'h0000_0000; xita2 = 32'h00B4_0000;
      @(negedge clk);
      checks++; if (pwm1 !== 1'b0 || pwm2 !== 1'b0) begin failures++; $display("FAIL enable_drop: got %b%b expected 00", pwm1, pwm2); end
      ps = 0; h1 = 0;
      for (int i = 0; i < 20; i++) begin
         angle_valid = (i < 4);
         if (period_start === 1'b1) ps++;
         if (pwm1 === 1'b1 || pwm2 === 1'b1) h1++;
         @(negedge clk);
      end
      checks++; if (ps !== 0 || h1 !== 0) begin failures++; $display("FAIL enable_idle: got period_start=%0d pwm_high=%0d expected 0/0", ps, h1); end
      enable = 1'b1;
      n = 0; h1 = 0; h2 = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            checks++;
            if (pwm1 !== 1'b1 || pwm2 !== 1'b1) begin failures++; $display("FAIL enable_restart: got %b%b expected 11", pwm1, pwm2); end
         end
         if (pwm1 === 1'b1) h1++;
         if (pwm2 === 1'b1) h2++;
      end while (period_start !== 1'b1 && n < 2 * PER_CLK);
      checks++; if (n !== PER_CLK) begin failures++; $display("FAIL enable_period: got %0d clocks expected %0d", n, PER_CLK); end
      checks++; if (h1 !== 3998 || h2 !== 2998) begin failures++; $display("FAIL enable_first_width: got %0d/%0d expected 3998/2998", h1, h2); end
      measure("enable_apply", -1, 32'd0, 32'd0, -1, 32'd0, 32'd0, h1, h2, ps);
      checks++; if (ps !== 1 || h1 !== 1000 || h2 !== 4998) begin failures++; $display("FAIL enable_apply: got ap=%0d %0d/%0d expected ap=1 1000/4998", ps, h1, h2); end
   endtask

   task automatic test_async_reset();
      wait_start("async");
      repeat (100) @(negedge clk);
      checks++; if (pwm2 !== 1'b1) begin failures++; $display("FAIL async_pre: got %b expected 1", pwm2); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (pwm1 !== 1'b0 || pwm2 !== 1'b0) begin failures++; $display("FAIL async_reset_pwm: got %b%b expected 00", pwm1, pwm2); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_update();
      test_clamp();
      test_latest_wins();
      test_enable();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/servo_pwm_out.md
Name: servo_pwm_out

Overview:
- Downstream consumer of the inverse-kinematics stage. Takes the two joint angles (xita1 = lower servo, xita2 = upper servo) plus their valid flag, and generates two hobby-servo PWM waveforms.
- Clamps angles to 0..180 deg and converts each to a pulse width in microseconds.
- New widths take effect only at a PWM period boundary, so no pulse is ever truncated or stretched mid-period.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency; must be an integer multiple of 1 MHz.
- PERIOD_US, 20000, PWM period in microseconds.
- MIN_US, 500, pulse width at 0 deg.
- SCALE, 2844, width gain: us per deg in Q8.8 input, times 65536/256 (≈ 2000/180 × 256).
- RESET_US, 1500, pulse width applied from reset until the first angle update.
- SLEW_US, 20, max width change per period per channel (used only with the optional feature).

Ports:
- clk  in  1  system clock, posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  1 = run PWM; 0 = outputs low, counters held at 0.
- angle_valid  in  1  level flag from the IK stage; a new angle pair is captured on its 0→1 edge.
- xita1  in  32  lower servo angle, deg, sign-magnitude: bit31 sign, [30:16] integer, [15:0] fraction.
- xita2  in  32  upper servo angle, same format.
- pwm1  out  1  lower servo PWM.
- pwm2  out  1  upper servo PWM.
- period_start  out  1  one-cycle pulse on every period wrap.
- applied  out  1  one-cycle pulse when a pending angle pair is loaded into the active widths.

Behaviour:
- Reset (async assert, sync release internally):
  - pwm1 = pwm2 = 0, period_start = applied = 0.
  - Prescaler and us_cnt = 0, pending_valid = 0.
  - Both active widths = RESET_US.
- Prescaler:
  - tick pulses one cycle every CLK_HZ/1e6 clocks.
  - us_cnt increments on tick and wraps PERIOD_US-1 → 0.
  - The wrapping tick is the period boundary; period_start is asserted that cycle.
- Capture:
  - angle_valid_d is angle_valid registered.
  - On angle_valid && !angle_valid_d (cycle t), xita1/xita2 are registered.
  - Conversion results are registered at t+1; pending widths are written and pending_valid is set at t+2.
  - A new edge before the pending pair is applied overwrites it: latest pair wins.
- Conversion, per channel:
  - If bit31 = 1 or magnitude = 0, the angle is 0.
  - If magnitude > 32'h00B4_0000, the angle is clamped to 180.0.
  - a88 = magnitude[23:8] (Q8.8, max 46080).
  - width_us = MIN_US + ((a88 × SCALE) >> 16), computed with a 32-bit product.
  - Defaults: 0 → 500, 90 → 1499, 180 → 2499.
- Apply:
  - At a period boundary with pending_valid = 1: active widths ← pending, pending_valid ← 0, applied = 1 for that cycle.
  - If pending_valid becomes 1 in the same cycle as the boundary, apply is deferred to the next boundary.
- Output:
  - pwmN is registered as (us_cnt < active_N) && enable.
  - It is high for exactly active_N × CLK_HZ/1e6 clocks per period, ±1 clock of registration offset.
- enable = 0:
  - Prescaler and us_cnt are held at 0; pwm outputs are 0; period_start is 0.
  - Capture still runs. Apply happens at the first boundary after enable returns.
  - On re-enable, the first period begins with us_cnt = 0.
- Reset mid-period: all state returns to reset values immediately; pwm goes low asynchronously.
- xita1 and xita2 are independent paths; one channel clamping does not affect the other.

Optional Feature:
- Macro: SERVO_SLEW_EN.
- Defined: the apply step moves each active width toward its pending target by at most SLEW_US per period boundary.
  - pending_valid stays set until both channels reach their targets.
  - applied pulses only on the boundary where both widths equal their targets.
- Undefined: the active width jumps to the target in one boundary, as described above; the SLEW_US parameter is ignored.

Decomposition:
- servo_pkg holds:
  - Q16.16 sign-magnitude field positions.
  - ANG_MAX_Q = 32'h00B4_0000.
  - A us-width typedef of 16 bits.
  - A clamp function: sign/zero → 0, >180 → 180.
- One sub-module, servo_angle2us: clamp plus scale, one registered stage. It is instantiated twice, once per channel.
- Prescaler, period counter, capture edge detect and apply logic stay in servo_pwm_out.

Test Plan:
- Release reset with enable = 1 and no valid → pwm1 and pwm2 high for 1500 us of every 20000 us period; applied never asserts.
- Pulse angle_valid with xita1 = 32'h005A_0000 and xita2 = 0 mid-period → current period unchanged; at the next boundary applied = 1; pwm1 = 1499 us, pwm2 = 500 us.
- xita1 = 32'h80_1E_0000 (-30 deg) and xita2 = 32'h00C8_0000 (200 deg) → pwm1 = 500 us, pwm2 = 2499 us.
- Two valid edges within one period, first 45 deg then 135 deg → only 135 deg is applied (width 1999 us); exactly one applied pulse.
- Drop enable mid-pulse → pwm low within 1 clock; raise enable → pwm high at us_cnt = 0; a period of 20000 us is measured from the re-enable.
- With SERVO_SLEW_EN, step from 500 us to 2499 us → width increases 20 us per period; applied asserts at the boundary where the width first equals 2499 us.
